crc_engine: RTL

Parametrised, handshake-driven CRC generator/checker for the byte-stream datapaths. It folds one `DATA_WIDTH`-bit word per transaction into a running CRC register, `BITS_PER_CYCLE` bits per clock. It supports arbitrary polynomial, init value, input/output reflection and final XOR. It replaces the fixed 16-bit, toggle-triggered CRC checker wherever a configurable CRC is needed.

---
 rtl/crc_engine.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/crc_engine.sv
// crc_engine
//   Configurable CRC generator/checker. Each accepted DATA_WIDTH-bit word is
//   folded into a running CRC register BITS_PER_CYCLE bits per clock, MSB of
//   the (optionally bit-reversed) word first. The register persists across
//   words until i_clear or reset, so a message is a sequence of words.
//
// Ports
//   i_sys_clk      : system clock, rising edge
//   i_reset        : asynchronous active-high reset
//   i_clear        : synchronous restart; reloads INIT and aborts any word in flight
//   i_valid/i_data : input word handshake; word taken when i_valid && o_ready
//   o_ready        : combinational; high in IDLE while i_clear is low
//   o_done         : one-cycle pulse when a word has been folded
//   o_crc          : registered reflect_out(crc_reg) ^ XOR_OUT
//   o_residue_zero : registered; high when the raw CRC register is zero
module crc_engine #(
    parameter int unsigned CRC_WIDTH      = 16,
    parameter logic [31:0] POLYNOMIAL     = 32'h0000_1021,
    parameter logic [31:0] INIT           = 32'h0000_FFFF,
    parameter logic [31:0] XOR_OUT        = 32'h0000_0000,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter logic        REFLECT_IN     = 1'b0,
    parameter logic        REFLECT_OUT    = 1'b0
) (
    input  logic                  i_sys_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_done,
    output logic [CRC_WIDTH-1:0]  o_crc,
    output logic                  o_residue_zero
);

    localparam int unsigned STEPS = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(STEPS) + 1;

    // Parameters wider than the register contribute only their low bits.
    localparam logic [CRC_WIDTH-1:0] POLY_V = POLYNOMIAL[CRC_WIDTH-1:0];
    localparam logic [CRC_WIDTH-1:0] INIT_V = INIT[CRC_WIDTH-1:0];
    localparam logic [CRC_WIDTH-1:0] XOR_V  = XOR_OUT[CRC_WIDTH-1:0];

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [CRC_WIDTH-1:0]   crc_q, crc_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic [CRC_WIDTH-1:0]   crc_out_q, crc_out_d;
    logic                   rz_q, rz_d;

    logic [CRC_WIDTH-1:0]   crc_step;
    logic [DATA_WIDTH-1:0]  data_step;
    logic                   fb;

    function automatic logic [CRC_WIDTH-1:0] final_crc(input logic [CRC_WIDTH-1:0] v);
        logic [CRC_WIDTH-1:0] r;
        if (REFLECT_OUT) r = {<<{v}};
        else             r = v;
        return r ^ XOR_V;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_word(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        if (REFLECT_IN) r = {<<{v}};
        else            r = v;
        return r;
    endfunction

    assign o_ready        = (state_q == IDLE) && !i_clear;
    assign o_done         = done_q;
    assign o_crc          = crc_out_q;
    assign o_residue_zero = rz_q;

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        crc_out_d = crc_out_q;
        rz_d      = rz_q;
        crc_step  = crc_q;
        data_step = data_q;
        fb        = 1'b0;

        if (i_clear) begin
            state_d   = IDLE;
            crc_d     = INIT_V;
            crc_out_d = final_crc(INIT_V);
            rz_d      = (INIT_V == '0);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        data_d  = load_word(i_data);
                        cnt_d   = CNT_W'(STEPS);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    // Unrolled serial LFSR steps; the word is consumed from its MSB.
                    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
                        fb        = data_step[DATA_WIDTH-1] ^ crc_step[CRC_WIDTH-1];
                        crc_step  = {crc_step[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY_V : '0);
                        data_step = data_step << 1;
                    end
                    crc_d  = crc_step;
                    data_d = data_step;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        done_d    = 1'b1;
                        crc_out_d = final_crc(crc_step);
                        rz_d      = (crc_step == '0);
                        state_d   = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            crc_q     <= INIT_V;
            data_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            crc_out_q <= final_crc(INIT_V);
            rz_q      <= (INIT_V == '0);
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            crc_out_q <= crc_out_d;
            rz_q      <= rz_d;
        end
    end

endmodule
